// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared types and constants for the PC sequencer.
// Revision    : 1.0
// ============================================================================
package pc_sequencer_pkg;

    localparam int unsigned            c_pc_width = 32;
    localparam logic [c_pc_width-1:0]  c_pc_incr  = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_t;

    // Encoding order doubles as priority: a larger value wins.
    typedef enum logic [1:0] {
        RC_NONE = 2'd0,
        RC_JMP  = 2'd1,
        RC_BR   = 2'd2,
        RC_EXC  = 2'd3
    } redir_cls_t;

    function automatic logic [c_pc_width-1:0] align_target(input logic [c_pc_width-1:0] t);
        return {t[c_pc_width-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_redirect_arb.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_arb
// Description : Combinational redirect priority select with word alignment.
//               Exception level present only with PC_SEQ_EXC_EN.
// Revision    : 1.0
// ============================================================================
module pc_redirect_arb
    import pc_sequencer_pkg::*;
(
`ifdef PC_SEQ_EXC_EN
    input  logic                  exc_req,
    input  logic [c_pc_width-1:0] exc_target,
`endif
    input  logic                  br_taken,
    input  logic [c_pc_width-1:0] br_target,
    input  logic                  jmp_valid,
    input  logic [c_pc_width-1:0] jmp_target,
    output redir_cls_t            cls,
    output logic [c_pc_width-1:0] target
);

    always_comb begin
        cls    = RC_NONE;
        target = '0;
        if (br_taken) begin
            cls    = RC_BR;
            target = align_target(br_target);
        end else if (jmp_valid) begin
            cls    = RC_JMP;
            target = align_target(jmp_target);
        end
`ifdef PC_SEQ_EXC_EN
        if (exc_req) begin
            cls    = RC_EXC;
            target = align_target(exc_target);
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Next-PC selection, stall-safe redirect holding and flushes.
//               Optional exception path enabled by macro PC_SEQ_EXC_EN.
// Revision    : 1.0
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef PC_SEQ_EXC_EN
   ,parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [c_pc_width-1:0] pc,
    input  logic                  stall,
    input  logic                  br_taken,
    input  logic [c_pc_width-1:0] br_target,
    input  logic                  jmp_valid,
    input  logic [c_pc_width-1:0] jmp_target,
`ifdef PC_SEQ_EXC_EN
    input  logic                  exc_req,
    input  logic [c_pc_width-1:0] exc_pc,
    output logic [c_pc_width-1:0] epc,
`endif
    output logic [c_pc_width-1:0] pc_next,
    output logic                  pc_en,
    output logic                  flush_if,
    output logic                  flush_id,
    output logic                  fetch_valid,
    output logic [15:0]           redirect_cnt
);

    seq_state_t            r_state;
    seq_state_t            w_state_nxt;
    seq_state_t            w_state_eff;
    redir_cls_t            r_pend_cls;
    redir_cls_t            w_pend_cls_nxt;
    logic [c_pc_width-1:0] r_pend_tgt;
    logic [c_pc_width-1:0] w_pend_tgt_nxt;
    redir_cls_t            w_new_cls;
    logic [c_pc_width-1:0] w_new_tgt;
    redir_cls_t            w_app_cls;
    logic [c_pc_width-1:0] w_app_tgt;
    logic                  w_take_new;
    logic                  w_boot;
    logic [15:0]           r_cnt;

    pc_redirect_arb u_arb (
`ifdef PC_SEQ_EXC_EN
        .exc_req    (exc_req),
        .exc_target (EXC_VECTOR),
`endif
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .cls        (w_new_cls),
        .target     (w_new_tgt)
    );

    // Reset overrides the registered state so BOOT outputs appear immediately.
    assign w_state_eff = rst ? ST_BOOT : r_state;

    always_comb begin
        w_state_nxt    = r_state;
        w_pend_cls_nxt = r_pend_cls;
        w_pend_tgt_nxt = r_pend_tgt;
        w_app_cls      = RC_NONE;
        w_app_tgt      = w_new_tgt;
        w_take_new     = 1'b0;
        w_boot         = 1'b0;
        pc_en          = 1'b0;
        fetch_valid    = 1'b1;
        pc_next        = pc + c_pc_incr;

        case (w_state_eff)
            ST_BOOT: begin
                w_boot      = 1'b1;
                pc_en       = 1'b1;
                fetch_valid = 1'b0;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    pc_en = 1'b1;
                    if (w_new_cls != RC_NONE) begin
                        w_app_cls  = w_new_cls;
                        w_take_new = 1'b1;
                    end
                end else if (w_new_cls != RC_NONE) begin
                    w_pend_cls_nxt = w_new_cls;
                    w_pend_tgt_nxt = w_new_tgt;
                    w_take_new     = 1'b1;
                    w_state_nxt    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (stall) begin
                    if ((w_new_cls != RC_NONE) && (w_new_cls >= r_pend_cls)) begin
                        w_pend_cls_nxt = w_new_cls;
                        w_pend_tgt_nxt = w_new_tgt;
                        w_take_new     = 1'b1;
                    end
                end else begin
                    pc_en          = 1'b1;
                    w_state_nxt    = ST_RUN;
                    w_pend_cls_nxt = RC_NONE;
                    if (w_new_cls > r_pend_cls) begin
                        w_app_cls  = w_new_cls;
                        w_take_new = 1'b1;
                    end else begin
                        w_app_cls = r_pend_cls;
                        w_app_tgt = r_pend_tgt;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase

        if (w_boot) begin
            pc_next = RESET_VECTOR;
        end else if (w_app_cls != RC_NONE) begin
            pc_next = w_app_tgt;
        end

        flush_if = w_boot || (w_app_cls != RC_NONE);
        flush_id = w_boot || (w_app_cls == RC_BR) || (w_app_cls == RC_EXC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_pend_cls <= RC_NONE;
            r_pend_tgt <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pend_cls <= w_pend_cls_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
            if ((w_app_cls != RC_NONE) && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign redirect_cnt = r_cnt;

`ifdef PC_SEQ_EXC_EN
    logic [c_pc_width-1:0] r_epc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_epc <= '0;
        end else if (w_take_new && (w_new_cls == RC_EXC)) begin
            r_epc <= exc_pc;
        end
    end

    assign epc = r_epc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed vector bench for pc_sequencer.
// Revision    : 1.0
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        flush_if;
    logic        flush_id;
    logic        fetch_valid;
    logic [15:0] redirect_cnt;
`ifdef PC_SEQ_EXC_EN
    logic        exc_req;
    logic [31:0] exc_pc;
    logic [31:0] epc;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;
    logic [31:0] cap_next;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jmp_valid    (jmp_valid),
        .jmp_target   (jmp_target),
`ifdef PC_SEQ_EXC_EN
        .exc_req      (exc_req),
        .exc_pc       (exc_pc),
        .epc          (epc),
`endif
        .pc_next      (pc_next),
        .pc_en        (pc_en),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .fetch_valid  (fetch_valid),
        .redirect_cnt (redirect_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic        br;
        logic [31:0] brt;
        logic        jv;
        logic [31:0] jt;
        logic [31:0] exp_next;
        logic        exp_fi;
        logic        exp_fd;
        int          exp_cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] nxt, input logic en,
                            input logic fi, input logic fd, input logic fv);
        chk({tag, ".pc_next"},     pc_next,             nxt);
        chk({tag, ".pc_en"},       {31'd0, pc_en},      {31'd0, en});
        chk({tag, ".flush_if"},    {31'd0, flush_if},   {31'd0, fi});
        chk({tag, ".flush_id"},    {31'd0, flush_id},   {31'd0, fd});
        chk({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, fv});
    endtask

    task automatic set_in(input logic [31:0] p, input logic b, input logic [31:0] bt,
                          input logic j, input logic [31:0] jt, input logic s);
        pc         = p;
        br_taken   = b;
        br_target  = bt;
        jmp_valid  = j;
        jmp_target = jt;
        stall      = s;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string nm);
        chk(nm, {16'd0, redirect_cnt}, exp_cnt[31:0]);
    endtask

    // Drive during a stall; only the frozen load enable is expected.
    task automatic stall_step(input string nm, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt);
        set_in(32'h0000_1000, b, bt, j, jt, 1'b1);
        @(negedge clk);
        chk({nm, ".pc_en"}, {31'd0, pc_en}, 32'd0);
        next_cycle();
    endtask

    initial begin
        vecs[0] = '{32'h0000_0010, 1'b1, 32'h0000_0043, 1'b1, 32'h0000_0080, 32'h0000_0040, 1'b1, 1'b1, 1};
        vecs[1] = '{32'h0000_0040, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0044, 1'b0, 1'b0, 1};
        vecs[2] = '{32'h0000_0044, 1'b0, 32'h0,         1'b1, 32'h0000_0103, 32'h0000_0100, 1'b1, 1'b0, 2};
        vecs[3] = '{32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0000, 1'b0, 1'b0, 2};
        vecs[4] = '{32'h0000_0200, 1'b1, 32'h0000_0301, 1'b0, 32'h0,         32'h0000_0300, 1'b1, 1'b1, 3};
        vecs[5] = '{32'h1234_5678, 1'b0, 32'h0,         1'b0, 32'h0,         32'h1234_567C, 1'b0, 1'b0, 3};
        vecs[6] = '{32'h0000_0300, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEC, 1'b1, 1'b0, 4};
        vecs[7] = '{32'h0000_0400, 1'b1, 32'h7FFF_FFFE, 1'b1, 32'h0000_0010, 32'h7FFF_FFFC, 1'b1, 1'b1, 5};

        rst = 1'b1;
        set_in(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
`ifdef PC_SEQ_EXC_EN
        exc_req = 1'b0;
        exc_pc  = 32'h0;
`endif

        // Reset held two cycles, then BOOT and sequential run 0, 4, 8.
        next_cycle();
        @(negedge clk);
        chk_outs("rst1", 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        next_cycle();
        @(negedge clk);
        chk_outs("rst2", 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_cnt("rst2.cnt");
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk_outs("boot", 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        cap_next = pc_next;
        next_cycle();
        pc = cap_next;
        chk("run.pc0", pc, 32'h0);
        @(negedge clk);
        chk_outs("run0", 32'h4, 1'b1, 1'b0, 1'b0, 1'b1);
        cap_next = pc_next;
        next_cycle();
        pc = cap_next;
        chk("run.pc1", pc, 32'h4);
        @(negedge clk);
        chk_outs("run1", 32'h8, 1'b1, 1'b0, 1'b0, 1'b1);
        cap_next = pc_next;
        next_cycle();
        pc = cap_next;
        chk("run.pc2", pc, 32'h8);

        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].pc, vecs[i].br, vecs[i].brt, vecs[i].jv, vecs[i].jt, 1'b0);
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), vecs[i].exp_next, 1'b1,
                     vecs[i].exp_fi, vecs[i].exp_fd, 1'b1);
            next_cycle();
            exp_cnt = vecs[i].exp_cnt;
            chk_cnt($sformatf("vec%0d.cnt", i));
        end

        // Jump then branch under a 3-cycle stall: one load of the branch.
        stall_step("st_a", 1'b0, 32'h0,   1'b1, 32'h100);
        stall_step("st_b", 1'b1, 32'h200, 1'b0, 32'h0);
        stall_step("st_c", 1'b0, 32'h0,   1'b0, 32'h0);
        chk_cnt("st_c.cnt");
        set_in(32'h1000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk_outs("st_rel", 32'h200, 1'b1, 1'b1, 1'b1, 1'b1);
        next_cycle();
        exp_cnt++;
        chk_cnt("st_rel.cnt");
        set_in(32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk_outs("st_after", 32'h204, 1'b1, 1'b0, 1'b0, 1'b1);
        next_cycle();
        chk_cnt("st_after.cnt");

        // Pending branch beats later jumps, including one on the release cycle.
        stall_step("lo_a", 1'b1, 32'h500, 1'b0, 32'h0);
        stall_step("lo_b", 1'b0, 32'h0,   1'b1, 32'h600);
        set_in(32'h1000, 1'b0, 32'h0, 1'b1, 32'h700, 1'b0);
        @(negedge clk);
        chk_outs("lo_rel", 32'h500, 1'b1, 1'b1, 1'b1, 1'b1);
        next_cycle();
        exp_cnt++;
        set_in(32'h500, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk_outs("lo_after", 32'h504, 1'b1, 1'b0, 1'b0, 1'b1);
        next_cycle();
        chk_cnt("lo_after.cnt");

        // Branch arriving on the release cycle overrides a pending jump.
        stall_step("hi_a", 1'b0, 32'h0, 1'b1, 32'h900);
        set_in(32'h1000, 1'b1, 32'hA00, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk_outs("hi_rel", 32'hA00, 1'b1, 1'b1, 1'b1, 1'b1);
        next_cycle();
        exp_cnt++;
        chk_cnt("hi_rel.cnt");

        // Equal-priority redirect during a stall replaces the pending one.
        stall_step("eq_a", 1'b1, 32'hB00, 1'b0, 32'h0);
        stall_step("eq_b", 1'b1, 32'hC00, 1'b0, 32'h0);
        set_in(32'h1000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk_outs("eq_rel", 32'hC00, 1'b1, 1'b1, 1'b1, 1'b1);
        next_cycle();
        exp_cnt++;
        chk_cnt("eq_rel.cnt");

`ifdef PC_SEQ_EXC_EN
        // Exception during a stall overrides a pending branch.
        stall_step("ex_a", 1'b1, 32'h500, 1'b0, 32'h0);
        exc_req = 1'b1;
        exc_pc  = 32'h24;
        stall_step("ex_b", 1'b0, 32'h0, 1'b0, 32'h0);
        exc_req = 1'b0;
        exc_pc  = 32'h0;
        chk("ex_b.epc", epc, 32'h24);
        set_in(32'h1000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk_outs("ex_rel", 32'h80, 1'b1, 1'b1, 1'b1, 1'b1);
        next_cycle();
        exp_cnt++;
        chk_cnt("ex_rel.cnt");
        chk("ex_rel.epc", epc, 32'h24);
`endif

        // Reset while a branch is pending discards it.
        stall_step("rh_a", 1'b1, 32'h300, 1'b0, 32'h0);
        set_in(32'h1000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_outs("rh_rst", 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        next_cycle();
        rst = 1'b0;
        exp_cnt = 0;
        chk_cnt("rh_rst.cnt");
        @(negedge clk);
        chk_outs("rh_boot", 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        next_cycle();
        set_in(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk_outs("rh_run", 32'h4, 1'b1, 1'b0, 1'b0, 1'b1);
        next_cycle();
        chk_cnt("rh_run.cnt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
